// File: rtl/panel_ctrl.sv
// Front-panel control: synchronises and debounces switches and the step button, and
// produces a rate-programmable one-cycle CPU enable with single-step while paused.
module panel_ctrl #(
    parameter int ADDR_BITS  = 12,
    parameter int N          = 100_000_000,
    parameter int NUM_RATES  = 4,
    parameter int DEB_CYCLES = 1_000_000,
    parameter int RB         = (NUM_RATES > 1) ? $clog2(NUM_RATES) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_BITS+3:0]   SW,
    input  logic                   btn_step,
    output logic                   cpu_en,
    output logic                   cpu_go,
    output logic                   cpu_rst,
    output logic [RB-1:0]          rate_idx,
    output logic [2:0]             display_op,
    output logic [ADDR_BITS-3:0]   ram_display_addr
);

    localparam int NIN = ADDR_BITS + 5;
    localparam int BTN = ADDR_BITS + 4;
    localparam int PW  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int CW  = $clog2(N + 1);

    logic [NIN-1:0] r_sync1;
    logic [NIN-1:0] r_sync2;
    logic [NIN-1:0] w_db;
    logic [PW-1:0]  r_pre;
    logic           w_deb_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {btn_step, SW};
            r_sync2 <= r_sync1;
        end
    end

    assign w_deb_tick = (r_pre == PW'(DEB_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || w_deb_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PW'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NIN; gi++) begin : g_deb
            logic [1:0] r_cnt;
            logic       r_bit;

            // Any sample agreeing with the current level restarts the run of three.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= 2'd0;
                    r_bit <= 1'b0;
                end else if (w_deb_tick) begin
                    if (r_sync2[gi] != r_bit) begin
                        if (r_cnt == 2'd2) begin
                            r_bit <= r_sync2[gi];
                            r_cnt <= 2'd0;
                        end else begin
                            r_cnt <= r_cnt + 2'd1;
                        end
                    end else begin
                        r_cnt <= 2'd0;
                    end
                end
            end

            assign w_db[gi] = r_bit;
        end
    endgenerate

    logic r_sw2_prev;
    logic r_btn_prev;
    logic r_step_edge;
    logic r_step_pend;
    logic w_rate_edge;

    assign w_rate_edge = w_db[2] & ~r_sw2_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sw2_prev  <= 1'b0;
            r_btn_prev  <= 1'b0;
            r_step_edge <= 1'b0;
            r_step_pend <= 1'b0;
        end else begin
            r_sw2_prev  <= w_db[2];
            r_btn_prev  <= w_db[BTN];
            r_step_edge <= w_db[BTN] & ~r_btn_prev;
            r_step_pend <= r_step_edge & ~cpu_go & ~cpu_rst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_go           <= 1'b0;
            cpu_rst          <= 1'b1;
            display_op       <= 3'd0;
            ram_display_addr <= '0;
        end else begin
            cpu_go           <= w_db[0];
            cpu_rst          <= w_db[1];
            display_op       <= w_db[5:3];
            ram_display_addr <= w_db[ADDR_BITS+3:6];
        end
    end

    logic [CW-1:0] w_div_m1_tab [NUM_RATES];
    logic [CW-1:0] r_cnt;
    logic          w_tc;

    generate
        for (gi = 0; gi < NUM_RATES; gi++) begin : g_div
            localparam int DIV = ((N >> gi) > 0) ? (N >> gi) : 1;
            assign w_div_m1_tab[gi] = CW'(DIV - 1);
        end
    endgenerate

    assign w_tc = (r_cnt == w_div_m1_tab[rate_idx]);

    // A rate change takes priority over a coincident terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            rate_idx <= '0;
            r_cnt    <= '0;
        end else if (w_rate_edge) begin
            rate_idx <= (rate_idx == RB'(NUM_RATES - 1)) ? '0 : rate_idx + RB'(1);
            r_cnt    <= '0;
        end else if (cpu_rst) begin
            r_cnt <= '0;
        end else if (cpu_go) begin
            r_cnt <= w_tc ? '0 : r_cnt + CW'(1);
        end
    end

    assign cpu_en = ~cpu_rst & (cpu_go ? (w_tc & ~w_rate_edge) : r_step_pend);

endmodule
